// File: rtl/cva6_obi_arb_adapter.sv
// cva6_obi_arb_adapter: round-robin merge of NumPorts YPB request channels onto one OBI master port
// Ports: req_* per-port address phase (valid/fields in, one-hot grant out); rsp_* per-port response
// (one-hot valid out, ready in, broadcast rdata/err); obi_* OBI master port with inverted parities;
// flush_i/flush_ack_o drain handshake; idle_o nothing pending; proto_err_o sticky protocol error.
module cva6_obi_arb_adapter #(
  parameter int NumPorts       = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int IdWidth        = 4,
  parameter int MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               req_valid_i,
  input  logic [NumPorts*AddrWidth-1:0]     req_addr_i,
  input  logic [NumPorts-1:0]               req_we_i,
  input  logic [NumPorts*DataWidth/8-1:0]   req_be_i,
  input  logic [NumPorts*DataWidth-1:0]     req_wdata_i,
  input  logic [NumPorts-1:0]               req_cacheable_i,
  input  logic [NumPorts-1:0]               req_access_type_i,
  output logic [NumPorts-1:0]               req_gnt_o,
  output logic [NumPorts-1:0]               rsp_valid_o,
  input  logic [NumPorts-1:0]               rsp_ready_i,
  output logic [DataWidth-1:0]              rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              obi_req_o,
  output logic                              obi_reqpar_o,
  input  logic                              obi_gnt_i,
  output logic [AddrWidth-1:0]              obi_addr_o,
  output logic                              obi_we_o,
  output logic [DataWidth/8-1:0]            obi_be_o,
  output logic [DataWidth-1:0]              obi_wdata_o,
  output logic [IdWidth-1:0]                obi_aid_o,
  output logic [1:0]                        obi_memtype_o,
  output logic [2:0]                        obi_prot_o,
  input  logic                              obi_rvalid_i,
  output logic                              obi_rready_o,
  output logic                              obi_rreadypar_o,
  input  logic [DataWidth-1:0]              obi_rdata_i,
  input  logic [IdWidth-1:0]                obi_rid_i,
  input  logic                              obi_err_i,
  input  logic                              flush_i,
  output logic                              flush_ack_o,
  output logic                              idle_o,
  output logic                              proto_err_o
);
  localparam int PW = $clog2(NumPorts);
  localparam int FW = $clog2(MaxOutstanding);
  localparam int BW = DataWidth / 8;
  typedef enum logic {ARB_IDLE, ARB_LOCK} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, lock_q, lock_d, sel, cur, head, k;
  logic [PW-1:0] fifo_q [MaxOutstanding];
  logic [PW-1:0] fifo_d [MaxOutstanding];
  logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FW:0] cnt_q, cnt_d;
  logic err_q, err_d, found, full, empty, push, pop;
  // first requester at or after the round-robin pointer
  always_comb begin
    sel = rr_q;
    found = 1'b0;
    k = '0;
    for (int i = 0; i < NumPorts; i++) begin
      k = PW'((int'(rr_q) + i) % NumPorts);
      if (!found && req_valid_i[k]) begin
        found = 1'b1;
        sel = k;
      end
    end
  end
  always_comb begin
    full = cnt_q == (FW+1)'(MaxOutstanding);
    empty = cnt_q == '0;
    head = fifo_q[rd_q];
    // a locked request is held to its grant regardless of flush or upstream behaviour
    cur = state_q == ARB_LOCK ? lock_q : sel;
    obi_req_o = state_q == ARB_LOCK || (found && !full && !flush_i);
    push = obi_req_o && obi_gnt_i;
    // ready is forced low while reset is applied; with nothing outstanding, stray responses are drained
    obi_rready_o = !rst_i && (empty || rsp_ready_i[head]);
    pop = !empty && obi_rvalid_i && obi_rready_o;
    obi_reqpar_o = !obi_req_o;
    obi_rreadypar_o = !obi_rready_o;
    obi_addr_o = obi_req_o ? req_addr_i[int'(cur)*AddrWidth +: AddrWidth] : '0;
    obi_we_o = obi_req_o && req_we_i[cur];
    obi_be_o = obi_req_o ? req_be_i[int'(cur)*BW +: BW] : '0;
    obi_wdata_o = obi_req_o ? req_wdata_i[int'(cur)*DataWidth +: DataWidth] : '0;
    obi_aid_o = obi_req_o ? IdWidth'(cur) : '0;
    obi_memtype_o = obi_req_o ? {req_cacheable_i[cur], 1'b0} : 2'b00;
    obi_prot_o = obi_req_o ? {2'b11, req_access_type_i[cur]} : 3'b000;
    req_gnt_o = '0;
    req_gnt_o[cur] = push;
    rsp_valid_o = '0;
    rsp_valid_o[head] = obi_rvalid_i && !empty;
    rsp_rdata_o = obi_rdata_i;
    rsp_err_o = obi_err_i;
    flush_ack_o = flush_i && state_q == ARB_IDLE && empty;
    idle_o = empty && state_q == ARB_IDLE && !obi_req_o;
    proto_err_o = err_q;
    state_d = obi_req_o && !obi_gnt_i ? ARB_LOCK : ARB_IDLE;
    lock_d = cur;
    rr_d = push ? (cur == PW'(NumPorts - 1) ? '0 : cur + 1'b1) : rr_q;
    wr_d = wr_q + FW'(push);
    rd_d = rd_q + FW'(pop);
    cnt_d = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = cur;
    err_d = err_q || (state_q == ARB_LOCK && !req_valid_i[lock_q]) ||
            (obi_rvalid_i && (empty || obi_rid_i != IdWidth'(head)));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      rr_q <= '0;
      lock_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      fifo_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      lock_q <= lock_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fifo_q <= fifo_d;
    end
  end
endmodule

// File: tb/tb_cva6_obi_arb_adapter.sv
// tb_cva6_obi_arb_adapter: directed and randomized scoreboard bench for cva6_obi_arb_adapter
module tb_cva6_obi_arb_adapter;
  localparam int N = 4, AW = 32, DW = 64, BW = DW / 8, IW = 4, MO = 4;
  typedef struct {int port; logic [DW-1:0] data; logic err;} exp_t;
  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic err;} slv_t;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0, req_we = '0, req_cacheable = '0, req_access = '0, rsp_ready = '1;
  logic [N-1:0] req_gnt, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*BW-1:0] req_be = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, obi_wdata, obi_rdata;
  logic rsp_err, obi_req, obi_reqpar, obi_gnt, obi_we, obi_rvalid, obi_rready, obi_rreadypar, obi_err;
  logic [AW-1:0] obi_addr;
  logic [BW-1:0] obi_be;
  logic [IW-1:0] obi_aid, obi_rid;
  logic [1:0] obi_memtype;
  logic [2:0] obi_prot;
  logic flush, flush_ack, idle, proto_err;
  int d_chk = 0, d_fail = 0, m_chk = 0, m_fail = 0;
  exp_t exp_q[$];
  slv_t slv_q[$];
  bit mon_on = 0, locked, ereq, hs_last;
  int rr_m, cnt_m, lock_p, ep, gp, h;
  logic [N-1:0] egnt, gnt_last;
  int heads[4] = '{0, 2, 0, 2};

  cva6_obi_arb_adapter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr), .req_we_i(req_we),
    .req_be_i(req_be), .req_wdata_i(req_wdata), .req_cacheable_i(req_cacheable),
    .req_access_type_i(req_access), .req_gnt_o(req_gnt), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .obi_req_o(obi_req),
    .obi_reqpar_o(obi_reqpar), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_aid_o(obi_aid), .obi_memtype_o(obi_memtype),
    .obi_prot_o(obi_prot), .obi_rvalid_i(obi_rvalid), .obi_rready_o(obi_rready),
    .obi_rreadypar_o(obi_rreadypar), .obi_rdata_i(obi_rdata), .obi_rid_i(obi_rid),
    .obi_err_i(obi_err), .flush_i(flush), .flush_ack_o(flush_ack), .idle_o(idle),
    .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] resp_data(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    return we ? ~wd : {a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    d_chk++;
    if (got !== exp) begin
      d_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_m(input string nm, input logic [63:0] got, input logic [63:0] exp);
    m_chk++;
    if (got !== exp) begin
      m_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic we, input logic c, input logic acc);
    req_valid[p] = 1'b1;
    req_addr[p*AW +: AW] = a;
    req_we[p] = we;
    req_cacheable[p] = c;
    req_access[p] = acc;
    req_be[p*BW +: BW] = BW'($urandom);
    req_wdata[p*DW +: DW] = {$urandom, $urandom};
  endtask

  // randomized upstream ports and OBI slave; responses come from the slave's in-order queue
  task automatic drive_rand(input bit new_ok);
    nx;
    for (int p = 0; p < N; p++) begin
      if (gnt_last[p]) req_valid[p] = 1'b0;
      if (new_ok && !req_valid[p] && $urandom_range(0, 2) == 0)
        set_req(p, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    obi_gnt = $urandom_range(0, 2) != 0;
    rsp_ready = N'($urandom | $urandom);
    if (obi_rvalid && hs_last) obi_rvalid = 1'b0;
    if (!obi_rvalid && slv_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      obi_rvalid = 1'b1;
      obi_rid = slv_q[0].id;
      obi_rdata = slv_q[0].data;
      obi_err = slv_q[0].err;
    end
  endtask

  // monitor: rule-level arbitration model plus response scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rr_m = 0; cnt_m = 0; locked = 0; lock_p = 0; gnt_last = '0; hs_last = 0;
      exp_q.delete();
      slv_q.delete();
    end else if (mon_on) begin
      ep = -1;
      for (int i = 0; i < N; i++)
        if (ep < 0 && req_valid[(rr_m + i) % N]) ep = (rr_m + i) % N;
      ereq = locked || (ep >= 0 && cnt_m < MO && !flush);
      gp = locked ? lock_p : ep;
      chk_m("obi_req", obi_req, ereq);
      chk_m("obi_reqpar", obi_reqpar, !ereq);
      egnt = '0;
      if (ereq) begin
        chk_m("aid", obi_aid, gp);
        chk_m("addr", obi_addr, req_addr[gp*AW +: AW]);
        chk_m("we_be", {obi_we, obi_be}, {req_we[gp], req_be[gp*BW +: BW]});
        chk_m("memtype_prot", {obi_memtype, obi_prot}, {req_cacheable[gp], 1'b0, 2'b11, req_access[gp]});
        if (obi_gnt) egnt = N'(1) << gp;
      end
      chk_m("req_gnt", req_gnt, egnt);
      if (ereq && obi_gnt) begin
        exp_q.push_back('{gp, resp_data(req_addr[gp*AW +: AW], req_we[gp], req_wdata[gp*DW +: DW]), req_addr[gp*AW + 4]});
        slv_q.push_back('{obi_aid, resp_data(obi_addr, obi_we, obi_wdata), obi_addr[4]});
        rr_m = (gp + 1) % N;
        locked = 0;
        cnt_m++;
      end else if (ereq) begin
        locked = 1;
        lock_p = gp;
      end
      gnt_last = req_gnt;
      hs_last = obi_rvalid && obi_rready;
      if (obi_rvalid && exp_q.size() > 0) begin
        h = exp_q[0].port;
        chk_m("rsp_valid", rsp_valid, N'(1) << h);
        chk_m("obi_rready", obi_rready, rsp_ready[h]);
        if (obi_rready) begin
          chk_m("rsp_data", {rsp_err, rsp_rdata}, {exp_q[0].err, exp_q[0].data});
          exp_q.pop_front();
          slv_q.pop_front();
          cnt_m--;
        end
      end else chk_m("rsp_valid_idle", rsp_valid, 0);
      chk_m("proto_err_rand", proto_err, 0);
    end
  end

  initial begin
    obi_gnt = 0; obi_rvalid = 0; obi_rid = 0; obi_rdata = 0; obi_err = 0; flush = 0;
    #1 rst = 1;
    #2;
    chk("rst_outs", {req_gnt, rsp_valid, obi_req, obi_rready, flush_ack, proto_err, obi_aid}, 0);
    chk("rst_par_idle", {obi_reqpar, obi_rreadypar, idle}, 3'b111);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // round robin over ports 0 and 2, then fill the outstanding FIFO
    set_req(0, 32'h1000, 0, 0, 0);
    set_req(2, 32'h2000, 0, 1, 1);
    obi_gnt = 1;
    rsp_ready = '1;
    @(negedge clk);
    chk("rr_a_gnt", req_gnt, 4'b0001);
    chk("rr_a_fields", {obi_aid, obi_addr, obi_memtype, obi_prot}, {4'd0, 32'h1000, 2'b00, 3'b110});
    nx; @(negedge clk);
    chk("rr_b_gnt", req_gnt, 4'b0100);
    chk("rr_b_fields", {obi_aid, obi_addr, obi_memtype, obi_prot}, {4'd2, 32'h2000, 2'b10, 3'b111});
    nx; @(negedge clk);
    chk("rr_c", {req_gnt, obi_aid}, {4'b0001, 4'd0});
    nx; @(negedge clk);
    chk("rr_d", {req_gnt, obi_aid}, {4'b0100, 4'd2});
    nx; @(negedge clk);
    chk("full_blocks", {obi_req, req_gnt, idle}, 0);
    nx;
    obi_rvalid = 1; obi_rid = 0; obi_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("pop_full", {rsp_valid, obi_rready, obi_req}, {4'b0001, 1'b1, 1'b0});
    chk("rdata_0", rsp_rdata, 64'hDEAD_BEEF);
    nx;
    obi_rid = 2; obi_rdata = 64'h2222;
    @(negedge clk);
    chk("push_pop", {req_gnt, rsp_valid}, {4'b0001, 4'b0100});
    nx;
    obi_rvalid = 0;
    @(negedge clk);
    chk("refill", req_gnt, 4'b0100);
    nx; @(negedge clk);
    chk("full_again", obi_req, 0);
    // flush with four outstanding; head port 0 stalls for two cycles
    nx;
    req_valid = '0;
    set_req(1, 32'h1111_0000, 0, 1, 1);
    flush = 1;
    for (int i = 0; i < 4; i++) begin
      obi_rvalid = 1; obi_rid = IW'(heads[i]); obi_rdata = 64'hDEAD_BEEF + 64'(i);
      if (i == 0) begin
        rsp_ready = 4'b1110;
        repeat (2) begin
          @(negedge clk);
          chk("stall", {rsp_valid, obi_rready, obi_rreadypar, flush_ack, req_gnt}, {4'b0001, 1'b0, 1'b1, 1'b0, 4'b0});
          nx;
        end
        rsp_ready = '1;
      end
      @(negedge clk);
      chk("drain_rsp", {rsp_valid, obi_rready, flush_ack, req_gnt}, {4'(1 << heads[i]), 1'b1, 1'b0, 4'b0});
      chk("drain_data", rsp_rdata, 64'hDEAD_BEEF + 64'(i));
      nx;
    end
    obi_rvalid = 0;
    obi_gnt = 0;
    @(negedge clk);
    chk("flush_ack", {flush_ack, idle, obi_req}, 3'b110);
    // request lock: port 1 held for four cycles while port 3 joins
    nx;
    flush = 0;
    @(negedge clk);
    chk("lock_1", {obi_req, req_gnt, obi_aid, obi_memtype, obi_prot}, {1'b1, 4'b0, 4'd1, 2'b10, 3'b111});
    nx;
    set_req(3, 32'h3333_0000, 0, 0, 0);
    @(negedge clk);
    chk("lock_2", {obi_aid, obi_addr, req_gnt}, {4'd1, 32'h1111_0000, 4'b0});
    nx; @(negedge clk);
    chk("lock_3", {obi_aid, obi_addr, req_gnt}, {4'd1, 32'h1111_0000, 4'b0});
    nx;
    obi_gnt = 1;
    @(negedge clk);
    chk("lock_gnt", {obi_aid, req_gnt}, {4'd1, 4'b0010});
    nx;
    req_valid[1] = 0;
    @(negedge clk);
    chk("next_p3", {obi_aid, req_gnt, proto_err}, {4'd3, 4'b1000, 1'b0});
    // valid dropped while locked
    nx;
    req_valid = '0;
    obi_gnt = 0;
    set_req(0, 32'h1000, 0, 0, 0);
    @(negedge clk);
    chk("drop_a", {obi_req, obi_aid}, {1'b1, 4'd0});
    nx;
    req_valid = '0;
    @(negedge clk);
    chk("drop_held", {obi_req, obi_aid, proto_err}, {1'b1, 4'd0, 1'b0});
    nx;
    obi_gnt = 1;
    @(negedge clk);
    chk("drop_err", {proto_err, req_gnt}, {1'b1, 4'b0001});
    nx;
    obi_gnt = 0;
    @(negedge clk);
    chk("drop_sticky", {obi_req, proto_err, idle}, 3'b010);
    // asynchronous reset between edges
    nx;
    #2 rst = 1;
    #1;
    chk("async_rst", {proto_err, idle, obi_rready, obi_rreadypar}, 4'b0101);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst", {idle, proto_err, obi_rready, flush_ack}, 4'b1010);
    // response with nothing outstanding
    nx;
    obi_rvalid = 1; obi_rid = 0;
    @(negedge clk);
    chk("stray_rsp", {rsp_valid, obi_rready, proto_err}, {4'b0, 1'b1, 1'b0});
    nx;
    obi_rvalid = 0;
    @(negedge clk);
    chk("stray_err", proto_err, 1);
    nx; @(negedge clk);
    chk("stray_sticky", proto_err, 1);
    nx;
    rst = 1;
    nx;
    rst = 0;
    @(negedge clk);
    chk("err_cleared", {proto_err, idle}, 2'b01);
    // rid mismatch still delivers to the head port
    nx;
    set_req(2, 32'h2000, 0, 0, 0);
    obi_gnt = 1;
    @(negedge clk);
    chk("rid_issue", req_gnt, 4'b0100);
    nx;
    req_valid = '0;
    obi_gnt = 0;
    obi_rvalid = 1; obi_rid = 1; obi_rdata = 64'h5555;
    @(negedge clk);
    chk("rid_deliver", {rsp_valid, proto_err}, {4'b0100, 1'b0});
    chk("rid_data", rsp_rdata, 64'h5555);
    nx;
    obi_rvalid = 0;
    @(negedge clk);
    chk("rid_err", {proto_err, idle}, 2'b11);
    // randomized traffic against the monitor's model
    nx;
    rst = 1;
    mon_on = 1;
    req_valid = '0;
    repeat (2) nx;
    rst = 0;
    repeat (3000) drive_rand(1);
    for (int c = 0; c < 400 && (exp_q.size() > 0 || req_valid != '0); c++) drive_rand(0);
    @(negedge clk);
    chk("drain_done", {32'(exp_q.size()), 28'(req_valid)}, 0);
    chk("idle_end", {idle, proto_err}, 2'b10);
    mon_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", d_chk + m_chk, d_fail + m_fail);
    $finish;
  end
endmodule
